// File: rtl/obi_arbiter_if.sv
// OBI arbiter bundle: N master request ports plus one shared slave port, with the sticky error flag.
// The arbiter binds the "slave" modport; the environment binds "master".
interface obi_arbiter_if #(
    parameter int NUM_MASTERS = 2
);
    logic [NUM_MASTERS-1:0]    m_req_i;
    logic [NUM_MASTERS-1:0]    m_gnt_o;
    logic [NUM_MASTERS*32-1:0] m_addr_i;
    logic [NUM_MASTERS-1:0]    m_we_i;
    logic [NUM_MASTERS*4-1:0]  m_be_i;
    logic [NUM_MASTERS*32-1:0] m_wdata_i;
    logic [NUM_MASTERS-1:0]    m_rvalid_o;
    logic [31:0]               m_rdata_o;
    logic                      s_req_o;
    logic                      s_gnt_i;
    logic [31:0]               s_addr_o;
    logic                      s_we_o;
    logic [3:0]                s_be_o;
    logic [31:0]               s_wdata_o;
    logic                      s_rvalid_i;
    logic [31:0]               s_rdata_i;
    logic                      err_o;

    modport slave (
        input  m_req_i, m_addr_i, m_we_i, m_be_i, m_wdata_i,
        input  s_gnt_i, s_rvalid_i, s_rdata_i,
        output m_gnt_o, m_rvalid_o, m_rdata_o,
        output s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o, err_o
    );

    modport master (
        output m_req_i, m_addr_i, m_we_i, m_be_i, m_wdata_i,
        output s_gnt_i, s_rvalid_i, s_rdata_i,
        input  m_gnt_o, m_rvalid_o, m_rdata_o,
        input  s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o, err_o
    );
endinterface

// File: rtl/obi_arbiter.sv
// Shares one OBI slave port among NUM_MASTERS masters, routing in-order responses via an ID FIFO.
// Define OBI_ARB_RR_EN for round-robin arbitration; default build is fixed priority (lowest index wins).
module obi_arbiter #(
    parameter int NUM_MASTERS     = 2,
    parameter int MAX_OUTSTANDING = 2,
    parameter int IDX_W           = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    obi_arbiter_if.slave  bus
);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [IDX_W-1:0] fifo_q [MAX_OUTSTANDING];
    logic [IDX_W-1:0] fifo_d [MAX_OUTSTANDING];
    logic             lock_q, lock_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
    logic             err_q, err_d;
`ifdef OBI_ARB_RR_EN
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
`endif

    logic             full;
    logic             s_req;
    logic             accept;
    logic             pop;
    logic [IDX_W-1:0] winner;

    // Handshake: an address phase transfers in the cycle where s_req_o && s_gnt_i;
    // a response transfers in any cycle with s_rvalid_i (no back-pressure on responses).
    assign full   = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign s_req  = !full && (lock_q || (|bus.m_req_i));
    assign accept = s_req && bus.s_gnt_i;
    assign pop    = bus.s_rvalid_i && (count_q != '0);

    always_comb begin
        int cand;
        cand   = 0;
        winner = '0;
        if (lock_q) begin
            winner = lock_idx_q;
        end else begin
`ifdef OBI_ARB_RR_EN
            // Descending scan so the requester closest to rr_ptr is assigned last and wins.
            for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
                cand = int'(rr_ptr_q) + i;
                if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
                if (bus.m_req_i[cand]) winner = IDX_W'(cand);
            end
`else
            for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
                cand = i;
                if (bus.m_req_i[cand]) winner = IDX_W'(cand);
            end
`endif
        end
    end

    assign bus.s_req_o   = s_req;
    assign bus.s_addr_o  = bus.m_addr_i[int'(winner)*32 +: 32];
    assign bus.s_we_o    = bus.m_we_i[winner];
    assign bus.s_be_o    = bus.m_be_i[int'(winner)*4 +: 4];
    assign bus.s_wdata_o = bus.m_wdata_i[int'(winner)*32 +: 32];
    assign bus.m_rdata_o = bus.s_rdata_i;
    assign bus.err_o     = err_q;

    always_comb begin
        bus.m_gnt_o    = '0;
        bus.m_rvalid_o = '0;
        if (accept) bus.m_gnt_o[winner] = 1'b1;
        if (pop) bus.m_rvalid_o[fifo_q[rd_ptr_q]] = 1'b1;
    end

    always_comb begin
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        fifo_d     = fifo_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        err_d      = err_q;
`ifdef OBI_ARB_RR_EN
        rr_ptr_d   = rr_ptr_q;
`endif
        if (accept) begin
            fifo_d[wr_ptr_q] = winner;
            wr_ptr_d = (wr_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + 1'b1;
`ifdef OBI_ARB_RR_EN
            rr_ptr_d = (winner == IDX_W'(NUM_MASTERS - 1)) ? '0 : winner + 1'b1;
`endif
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // Hold the chosen master until the slave grants, even if it withdraws its request.
        if (accept) begin
            lock_d = 1'b0;
        end else if (s_req) begin
            lock_d     = 1'b1;
            lock_idx_d = winner;
        end
        if (bus.s_rvalid_i && (count_q == '0)) err_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            fifo_q     <= '{default: '0};
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            err_q      <= 1'b0;
`ifdef OBI_ARB_RR_EN
            rr_ptr_q   <= '0;
`endif
        end else begin
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            fifo_q     <= fifo_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            err_q      <= err_d;
`ifdef OBI_ARB_RR_EN
            rr_ptr_q   <= rr_ptr_d;
`endif
        end
    end
endmodule
